// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  // Plain-vector state encoding keeps the FSM readable by older netlist tools.
  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t CALC   = 2'd1;
  localparam state_t FINISH = 2'd2;

endpackage

// File: rtl/mult_if.sv
// Start/busy/done handshake and operand/result bus between execute stage and multiplier.
interface mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output a, b, is_signed, start,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, is_signed, start,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_seq.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier for MULT/MULTU, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic   clock,
  input logic   reset,
  mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] p, input logic en);
    return en ? (~p + (2*WIDTH)'(1)) : p;
  endfunction

  // NOTE: every variable in a combinational block is assigned on every path, so no latch can form.
  always_comb begin
    sum     = acc + (mplier[0] ? {1'b0, mcand} : '0);
    product = negate({acc[WIDTH-1:0], mplier}, neg);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CALC;
            count    <= '0;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          {bus.hi, bus.lo} <= product;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath is deliberately left without reset; it is fully reloaded on every accepted start.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.start) begin
      mcand  <= magnitude(bus.a, bus.is_signed);
      mplier <= magnitude(bus.b, bus.is_signed);
      neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc    <= '0;
    end else if (state == CALC) begin
      {acc, mplier} <= {1'b0, sum, mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases, handshake scenarios and random operands
// compared against a plain-arithmetic 64-bit product model.
module tb_mult_seq;

  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mult_if bus ();

  mult_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one operation, optionally poke start mid-flight, wait for done and check everything.
  // idle_after=0 leaves the caller in the done cycle so it can chain a back-to-back start.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                       input int poke, input logic idle_after);
    logic [63:0] exp;
    int          n;
    exp           = model(x, y, s);
    bus.a         = x;
    bus.b         = y;
    bus.is_signed = s;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom);
    check({tag, "_busy_accept"}, {63'd0, bus.busy}, 64'd1);
    check({tag, "_done_accept"}, {63'd0, bus.done}, 64'd0);
    n = 0;
    while (!bus.done && n < 40) begin
      if (n == poke) begin
        bus.start = 1'b1;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp[63:32]});
    check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp[31:0]});
    if (idle_after) begin
      tick();
      check({tag, "_done_drop"}, {63'd0, bus.done}, 64'd0);
      check({tag, "_busy_drop"}, {63'd0, bus.busy}, 64'd0);
      check({tag, "_hold_lo"}, {32'd0, bus.lo}, {32'd0, exp[31:0]});
    end
  endtask

  initial begin
    logic        seen_done;
    logic [31:0] rx;
    logic [31:0] ry;

    reset         = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.start     = 1'b1;
    tick();
    tick();
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    tick();

    do_op("umax",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b1);
    check("umax_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("s_m1x7",    32'hFFFF_FFFF, 32'h0000_0007, 1'b1, -1, 1'b1);
    check("s_m1x7_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF9);
    do_op("u_m1x7",    32'hFFFF_FFFF, 32'h0000_0007, 1'b0, -1, 1'b1);
    check("u_m1x7_const", {bus.hi, bus.lo}, 64'h0000_0006_FFFF_FFF9);
    do_op("s_minsq",   32'h8000_0000, 32'h8000_0000, 1'b1, -1, 1'b1);
    check("s_minsq_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    do_op("s_minx1",   32'h8000_0000, 32'h0000_0001, 1'b1, -1, 1'b1);
    check("s_minx1_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);
    do_op("s_zero",    32'h0000_0000, 32'h8000_0000, 1'b1, -1, 1'b1);
    check("s_zero_const", {bus.hi, bus.lo}, 64'h0);

    // Start pulsed at cycle 10 of busy must be ignored.
    do_op("poke",      32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10, 1'b1);

    // Back-to-back: second start asserted in the done cycle.
    do_op("b2b_first", 32'h0000_0011, 32'h0000_0013, 1'b0, -1, 1'b0);
    do_op("b2b_second", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, -1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rx = $urandom;
      ry = $urandom;
      do_op($sformatf("rand%0d", i), rx, ry, 1'($urandom), -1, 1'b1);
    end

    // Reset mid-operation.
    do_op("pre_rst", 32'd3, 32'd5, 1'b0, -1, 1'b1);
    check("pre_rst_15", {32'd0, bus.lo}, 64'd15);
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b0;
    tick();
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    reset     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    check("midrst_no_done", {63'd0, seen_done}, 64'd0);
    do_op("post_rst", 32'd6, 32'd7, 1'b0, -1, 1'b1);
    check("post_rst_42", {32'd0, bus.lo}, 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
